// File: rtl/image_exchange_ctrl.sv
// Exchange-port controller for the image memory: streams a full image out over a
// valid/ready source, or loads a full image in from a valid/ready sink via port 1.
module image_exchange_ctrl #(
  parameter int A_W = 5,
  parameter int D_W = 1
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START_RD,
  input  logic           START_WR,
  output logic           BUSY,
  output logic           DONE,
  output logic [D_W-1:0] OUT_D,
  output logic           OUT_VALID,
  output logic           OUT_LAST,
  input  logic           OUT_READY,
  input  logic [D_W-1:0] IN_D,
  input  logic           IN_VALID,
  output logic           IN_READY,
  output logic [A_W-1:0] A_1,
  output logic [D_W-1:0] DI_1,
  output logic           WE_1,
  input  logic [D_W-1:0] DQ_1
);

  localparam logic [A_W-1:0] LAST_ADDR = {A_W{1'b1}};
  localparam logic [A_W-1:0] ADDR_ONE  = {{(A_W-1){1'b0}}, 1'b1};
  localparam logic [A_W-1:0] ADDR_ZERO = {A_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [A_W-1:0] cnt_q, cnt_d;
  logic           fetched_q, fetched_d;
  logic [D_W-1:0] out_d_q, out_d_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic [D_W-1:0] di_q, di_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           fetch_s;
  logic           wr_xfer_s;
  logic           rd_end_s;

  assign fetch_s   = (state_q == S_RD) && !fetched_q && (!out_valid_q || OUT_READY);
  assign wr_xfer_s = in_ready_q && IN_VALID;
  assign rd_end_s  = out_valid_q && OUT_READY && out_last_q;

  // Next-state and datapath computation for the whole controller
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fetched_d   = fetched_q;
    out_d_d     = out_d_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    di_d        = di_q;
    case (state_q)
      S_IDLE: begin
        if (START_RD) begin
          state_d   = S_RD;
          cnt_d     = ADDR_ZERO;
          fetched_d = 1'b0;
        end else if (START_WR) begin
          state_d = S_WR;
          cnt_d   = ADDR_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        // The last pixel is fetched only once; the counter wraps but fetched_q stops refetching.
        if (rd_end_s) begin
          state_d     = S_FIN;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else if (fetch_s) begin
          out_d_d     = DQ_1;
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == LAST_ADDR);
          fetched_d   = (cnt_q == LAST_ADDR);
          cnt_d       = cnt_q + ADDR_ONE;
        end else if (out_valid_q && OUT_READY) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      S_WR: begin
        if (wr_xfer_s) begin
          di_d  = IN_D;
          cnt_d = cnt_q + ADDR_ONE;
          if (cnt_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_WR;
          end
        end else begin
          di_d = di_q;
        end
      end
      // One idle cycle lets the memory commit the final registered write.
      S_DRAIN: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_WR);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
  end

  // Controller state and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= ADDR_ZERO;
      fetched_q   <= 1'b0;
      out_d_q     <= {D_W{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      di_q        <= {D_W{1'b0}};
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fetched_q   <= fetched_d;
      out_d_q     <= out_d_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      di_q        <= di_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign OUT_D     = out_d_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign IN_READY  = in_ready_q;
  assign A_1       = cnt_q;
  assign DI_1      = di_q;
  // Memory registers WE_1/A_1 itself, so these stay combinational.
  assign WE_1      = wr_xfer_s;

endmodule

// File: tb/tb_image_exchange_ctrl.sv
// Bench for image_exchange_ctrl: memory model with registered port-1 write,
// transaction-level reference model, directed scenarios then random traffic.
module tb_image_exchange_ctrl;
  localparam int A_W = 5;
  localparam int D_W = 1;
  localparam int N   = 32;

  logic           CLK, RST_N, START_RD, START_WR, BUSY, DONE;
  logic [D_W-1:0] OUT_D, IN_D, DI_1, DQ_1;
  logic           OUT_VALID, OUT_LAST, OUT_READY, IN_VALID, IN_READY, WE_1;
  logic [A_W-1:0] A_1;

  image_exchange_ctrl #(.A_W(A_W), .D_W(D_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START_RD(START_RD), .START_WR(START_WR),
    .BUSY(BUSY), .DONE(DONE), .OUT_D(OUT_D), .OUT_VALID(OUT_VALID),
    .OUT_LAST(OUT_LAST), .OUT_READY(OUT_READY), .IN_D(IN_D), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .A_1(A_1), .DI_1(DI_1), .WE_1(WE_1), .DQ_1(DQ_1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks, errors;
  int rdy_mode, in_mode, prod_idx;
  logic           pre_req;
  logic [D_W-1:0] pre_img [N];
  logic [D_W-1:0] mem [N];
  logic [D_W-1:0] exp_mem [N];
  logic           we_r;
  logic [A_W-1:0] a_r;

  // Image memory port 1: address/enable registered, data sampled at the write edge
  always @(posedge CLK) begin
    if (pre_req) begin
      for (int k = 0; k < N; k++) mem[k] <= pre_img[k];
    end else if (we_r === 1'b1) begin
      mem[a_r] <= DI_1;
    end
    we_r <= WE_1;
    a_r  <= A_1;
  end
  assign DQ_1 = mem[A_1];

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int op, rd_idx, rd_cyc, wr_idx, px_cnt, last_cnt, we_cnt;
  logic e_busy, e_done, e_inrdy, hold_v;
  logic [D_W-1:0] held;
  logic [D_W-1:0] captured [$];

  task model_loop;
    logic n_busy, n_done, n_inrdy;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        op = 0; rd_cyc = 0; hold_v = 1'b0;
        e_busy = 1'b0; e_done = 1'b0; e_inrdy = 1'b0;
      end else begin
        if (pre_req) for (int k = 0; k < N; k++) exp_mem[k] = pre_img[k];
        check1("busy", BUSY, e_busy);
        check1("done", DONE, e_done);
        check1("in_ready", IN_READY, e_inrdy);
        check1("out_valid", OUT_VALID, (op == 1 && rd_cyc >= 1));
        check1("we_1", WE_1, e_inrdy && IN_VALID);
        if (hold_v) check1("out_d_stable", OUT_D, held);
        if (WE_1) we_cnt++;
        n_busy = e_done ? 1'b0 : e_busy;
        n_done = 1'b0;
        n_inrdy = e_inrdy;
        hold_v = 1'b0;
        case (op)
          0: begin
            if (START_RD) begin
              op = 1; rd_idx = 0; rd_cyc = 0; n_busy = 1'b1;
            end else if (START_WR) begin
              op = 2; wr_idx = 0; n_inrdy = 1'b1; n_busy = 1'b1;
            end
          end
          1: begin
            rd_cyc++;
            if (OUT_VALID && OUT_READY) begin
              check1("out_d", OUT_D, exp_mem[rd_idx]);
              check1("out_last", OUT_LAST, rd_idx == N - 1);
              captured.push_back(OUT_D);
              px_cnt++;
              if (OUT_LAST) last_cnt++;
              rd_idx++;
              if (rd_idx == N) begin op = 4; n_done = 1'b1; end
            end else if (OUT_VALID) begin
              hold_v = 1'b1; held = OUT_D;
            end
          end
          2: begin
            if (IN_VALID) begin
              check1("a_1", A_1, wr_idx);
              exp_mem[wr_idx] = IN_D;
              wr_idx++;
              if (wr_idx == N) begin op = 3; n_inrdy = 1'b0; end
            end
          end
          3: begin op = 4; n_done = 1'b1; end
          default: op = 0;
        endcase
        e_busy = n_busy; e_done = n_done; e_inrdy = n_inrdy;
      end
    end
  endtask

  // Consumer: OUT_READY always high, 1,0,0,1 pattern, or random
  initial begin
    int ph;
    logic [3:0] pat;
    pat = 4'b1001;
    ph = 0;
    OUT_READY = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        0: OUT_READY = 1'b1;
        1: begin OUT_READY = pat[3 - ph]; ph = (ph + 1) % 4; end
        default: OUT_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Producer: tracks its own transfer index from the handshake it observes
  initial begin
    int idx;
    logic xfer, rdy_seen;
    idx = 0; IN_VALID = 1'b0; IN_D = {D_W{1'b0}}; prod_idx = 0;
    forever begin
      @(negedge CLK);
      xfer = IN_VALID && IN_READY;
      rdy_seen = IN_READY;
      @(posedge CLK); #1;
      if (xfer) idx++;
      else if (!rdy_seen) idx = 0;
      prod_idx = idx;
      case (in_mode)
        0: IN_VALID = 1'b0;
        1: begin IN_VALID = 1'b1; IN_D = (idx % 2 == 0) ? {D_W{1'b1}} : {D_W{1'b0}}; end
        default: begin IN_VALID = ($urandom_range(0, 3) != 0); IN_D = D_W'($urandom); end
      endcase
    end
  end

  task automatic pulse(input logic rd, input logic wr);
    @(posedge CLK); #1;
    START_RD = rd; START_WR = wr;
    @(posedge CLK); #1;
    START_RD = 1'b0; START_WR = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(negedge CLK);
      n++;
      if (DONE) break;
      if (n > 2000) begin
        checks++; errors++;
        $display("FAIL done_timeout: no DONE after %0d cycles, required within 2000", n);
        break;
      end
    end
  endtask

  task automatic preload();
    @(posedge CLK); #1; pre_req = 1'b1;
    @(posedge CLK); #1; pre_req = 1'b0;
  endtask

  initial begin
    int n, base_px, base_last, base_we;
    checks = 0; errors = 0; rdy_mode = 0; in_mode = 0;
    px_cnt = 0; last_cnt = 0; we_cnt = 0;
    RST_N = 1'b0; START_RD = 1'b0; START_WR = 1'b0; pre_req = 1'b0;
    fork model_loop(); join_none
    repeat (3) @(posedge CLK); #1;
    check1("rst_busy", BUSY, 0);       check1("rst_done", DONE, 0);
    check1("rst_out_valid", OUT_VALID, 0); check1("rst_out_last", OUT_LAST, 0);
    check1("rst_in_ready", IN_READY, 0);   check1("rst_we_1", WE_1, 0);
    check1("rst_a_1", A_1, 0); check1("rst_di_1", DI_1, 0); check1("rst_out_d", OUT_D, 0);
    RST_N = 1'b1;

    // Stream out a 0,0,0,0,1,1,1,1,... image at full rate
    for (int k = 0; k < N; k++) pre_img[k] = D_W'((k >> 2) & 1);
    preload();
    captured.delete(); base_px = px_cnt; base_last = last_cnt;
    pulse(1'b1, 1'b0);
    wait_done(n);
    check1("t1_done_latency", n, 34);
    check1("t1_pixels", px_cnt - base_px, 32);
    check1("t1_last_count", last_cnt - base_last, 1);
    check1("t1_captured", captured.size(), N);
    for (int k = 0; k < N && k < captured.size(); k++) check1("t1_pixel", captured[k], (k >> 2) & 1);

    // Back-pressured read
    rdy_mode = 1;
    captured.delete(); base_px = px_cnt;
    pulse(1'b1, 1'b0);
    wait_done(n);
    check1("t2_pixels", px_cnt - base_px, 32);
    for (int k = 0; k < N && k < captured.size(); k++) check1("t2_pixel", captured[k], (k >> 2) & 1);

    // Load ~k[0] then read it back the cycle after DONE
    rdy_mode = 0; in_mode = 1; base_we = we_cnt;
    pulse(1'b0, 1'b1);
    wait_done(n);
    check1("t3_done_latency", n, 34);
    check1("t3_we_cycles", we_cnt - base_we, 32);
    for (int k = 0; k < N; k++) check1("t3_mem", mem[k], (k % 2 == 0) ? 1 : 0);
    in_mode = 0;
    captured.delete();
    pulse(1'b1, 1'b0);
    wait_done(n);
    check1("t4_captured", captured.size(), N);
    for (int k = 0; k < N && k < captured.size(); k++) check1("t4_pixel", captured[k], (k % 2 == 0) ? 1 : 0);

    // Simultaneous starts, then write requests during the read
    in_mode = 2; base_px = px_cnt; base_we = we_cnt;
    pulse(1'b1, 1'b1);
    repeat (4) begin
      @(posedge CLK); #1; START_WR = 1'b1;
      @(posedge CLK); #1; START_WR = 1'b0;
    end
    wait_done(n);
    check1("t5_pixels", px_cnt - base_px, 32);
    check1("t5_no_writes", we_cnt - base_we, 0);

    // Reset in the middle of a load
    in_mode = 0;
    for (int k = 0; k < N; k++) pre_img[k] = {D_W{1'b1}};
    preload();
    in_mode = 1;
    pulse(1'b0, 1'b1);
    n = 0;
    forever begin
      @(posedge CLK); #2;
      n++;
      if (prod_idx == 10 || n > 100) break;
    end
    check1("t6_reached_10", prod_idx, 10);
    RST_N = 1'b0; #1;
    check1("t6_busy", BUSY, 0); check1("t6_we_1", WE_1, 0); check1("t6_in_ready", IN_READY, 0);
    repeat (2) @(posedge CLK); #1;
    RST_N = 1'b1; in_mode = 0;
    @(negedge CLK);
    for (int k = 0; k < N; k++) check1("t6_mem", mem[k], (k < 10) ? ((k % 2 == 0) ? 1 : 0) : 1);
    pulse(1'b1, 1'b0);
    wait_done(n);

    // Random traffic
    rdy_mode = 2; in_mode = 2;
    repeat (16) begin
      if ($urandom_range(0, 1) == 1) pulse(1'b1, 1'b0);
      else pulse(1'b0, 1'b1);
      wait_done(n);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end
    rdy_mode = 0; in_mode = 0;
    pulse(1'b1, 1'b0);
    wait_done(n);

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
